// File: rtl/spi_master_pkg.sv
// Shared SPI definitions: default frame size, SPI mode and the master state encoding.
package spi_master_pkg;

    localparam int SPI_FRAME_BITS = 32;
    localparam int SPI_MODE       = 0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SHIFT,
        ST_HOLD,
        ST_GAP
    } spi_state_e;

endpackage

// File: rtl/spi_clk_gen.sv
// SCLK divider: CLK_DIV cycles low then CLK_DIV cycles high while enabled, idles low.
// rise_o/fall_o are high in the cycle whose closing edge moves SCLK.
module spi_clk_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic en_i,
    output logic sclk_o,
    output logic rise_o,
    output logic fall_o
);

    localparam int DW = $clog2(CLK_DIV + 1);

    logic [DW-1:0] div_cnt;
    logic          half_done;

    assign half_done = en_i && (div_cnt == DW'(CLK_DIV - 1));
    assign rise_o    = half_done && !sclk_o;
    assign fall_o    = half_done && sclk_o;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i || !en_i) begin
            div_cnt <= '0;
            sclk_o  <= 1'b0;
        end else if (half_done) begin
            div_cnt <= '0;
            sclk_o  <= ~sclk_o;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/spi_master.sv
// Mode-0 SPI master: one MSB-first frame per start_i or per synchronized interrupt
// when auto_en_i is set, with programmable CS setup/hold/gap timing.
module spi_master
    import spi_master_pkg::*;
#(
    parameter int FRAME_BITS = SPI_FRAME_BITS,
    parameter int CLK_DIV    = 4,
    parameter int CS_SETUP   = 2,
    parameter int CS_HOLD    = 2,
    parameter int CS_GAP     = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  start_i,
    input  logic [FRAME_BITS-1:0] tx_data_i,
    input  logic                  auto_en_i,
    input  logic                  irq_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [FRAME_BITS-1:0] rx_data_o,
    output logic                  spi_sclk_o,
    output logic                  spi_cs_o,
    output logic                  spi_mosi_o,
    input  logic                  spi_miso_i
);

    localparam int BW = $clog2(FRAME_BITS + 1);
    localparam int PW = 16;

    spi_state_e            state;
    logic [PW-1:0]         ph_cnt;
    logic [BW-1:0]         bit_cnt;
    logic [FRAME_BITS-1:0] tx_sr;
    logic [FRAME_BITS-1:0] rx_sr;
    logic                  irq_s1, irq_s2, irq_s3, irq_pend;
    logic                  launch, sck_rise, sck_fall;

    assign launch = (state == ST_IDLE) && (start_i || (irq_pend && auto_en_i));

    spi_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .en_i    (state == ST_SHIFT),
        .sclk_o  (spi_sclk_o),
        .rise_o  (sck_rise),
        .fall_o  (sck_fall)
    );

    // A fresh edge coinciding with a launch stays pending for the next frame.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            irq_s1   <= 1'b0;
            irq_s2   <= 1'b0;
            irq_s3   <= 1'b0;
            irq_pend <= 1'b0;
        end else begin
            irq_s1 <= irq_i;
            irq_s2 <= irq_s1;
            irq_s3 <= irq_s2;
            if (!auto_en_i)            irq_pend <= 1'b0;
            else if (irq_s2 && !irq_s3) irq_pend <= 1'b1;
            else if (launch)           irq_pend <= 1'b0;
        end
    end

    // tx_sr holds the bits still to be sent; the bit on the wire lives in spi_mosi_o.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state      <= ST_IDLE;
            ph_cnt     <= '0;
            bit_cnt    <= '0;
            tx_sr      <= '0;
            rx_sr      <= '0;
            rx_data_o  <= '0;
            busy_o     <= 1'b0;
            done_o     <= 1'b0;
            spi_cs_o   <= 1'b1;
            spi_mosi_o <= 1'b0;
        end else begin
            done_o <= 1'b0;
            case (state)
                ST_IDLE: if (launch) begin
                    state      <= ST_SETUP;
                    ph_cnt     <= PW'(CS_SETUP - 1);
                    tx_sr      <= {tx_data_i[FRAME_BITS-2:0], 1'b0};
                    spi_mosi_o <= tx_data_i[FRAME_BITS-1];
                    spi_cs_o   <= 1'b0;
                    busy_o     <= 1'b1;
                end
                ST_SETUP: if (ph_cnt == '0) begin
                    state   <= ST_SHIFT;
                    bit_cnt <= '0;
                end else begin
                    ph_cnt <= ph_cnt - 1'b1;
                end
                ST_SHIFT: begin
                    if (sck_rise) rx_sr <= {rx_sr[FRAME_BITS-2:0], spi_miso_i};
                    if (sck_fall) begin
                        spi_mosi_o <= tx_sr[FRAME_BITS-1];
                        tx_sr      <= tx_sr << 1;
                        if (bit_cnt == BW'(FRAME_BITS - 1)) begin
                            state  <= ST_HOLD;
                            ph_cnt <= PW'(CS_HOLD - 1);
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                end
                ST_HOLD: if (ph_cnt == '0) begin
                    state      <= ST_GAP;
                    ph_cnt     <= PW'(CS_GAP - 1);
                    spi_cs_o   <= 1'b1;
                    spi_mosi_o <= 1'b0;
                    done_o     <= 1'b1;
                    rx_data_o  <= rx_sr;
                end else begin
                    ph_cnt <= ph_cnt - 1'b1;
                end
                ST_GAP: if (ph_cnt == '0) begin
                    state  <= ST_IDLE;
                    busy_o <= 1'b0;
                end else begin
                    ph_cnt <= ph_cnt - 1'b1;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master: default 32-bit instance plus an 8-bit / CLK_DIV=2 instance.
module tb_spi_master;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0, auto_en = 1'b0, irq = 1'b0;
    logic [31:0] tx = '0;
    logic        busy, done, sclk, cs, mosi, miso;
    logic [31:0] rx;

    logic       start8 = 1'b0;
    logic [7:0] tx8 = '0;
    logic       busy8, done8, sclk8, cs8, mosi8, miso8;
    logic [7:0] rx8;

    int checks = 0, errors = 0;

    always #5 clk = ~clk;

    spi_master dut (
        .clk_i(clk), .rst_n_i(rst_n), .start_i(start), .tx_data_i(tx),
        .auto_en_i(auto_en), .irq_i(irq), .busy_o(busy), .done_o(done),
        .rx_data_o(rx), .spi_sclk_o(sclk), .spi_cs_o(cs), .spi_mosi_o(mosi),
        .spi_miso_i(miso)
    );

    spi_master #(.FRAME_BITS(8), .CLK_DIV(2)) dut8 (
        .clk_i(clk), .rst_n_i(rst_n), .start_i(start8), .tx_data_i(tx8),
        .auto_en_i(1'b0), .irq_i(1'b0), .busy_o(busy8), .done_o(done8),
        .rx_data_o(rx8), .spi_sclk_o(sclk8), .spi_cs_o(cs8), .spi_mosi_o(mosi8),
        .spi_miso_i(miso8)
    );

    // Mode-0 slaves: load on CS fall, shift on SCLK fall; MOSI captured on SCLK rise.
    logic [31:0] slv_word = 32'h1234_5678, slv_sr = '0, cap = '0;
    logic [7:0]  slv8_word = 8'h5A, slv8_sr = '0, cap8 = '0;
    assign miso  = slv_sr[31];
    assign miso8 = slv8_sr[7];
    always @(negedge cs)    slv_sr = slv_word;
    always @(negedge sclk)  if (!cs) slv_sr = slv_sr << 1;
    always @(posedge sclk)  if (!cs) cap = {cap[30:0], mosi};
    always @(negedge cs8)   slv8_sr = slv8_word;
    always @(negedge sclk8) if (!cs8) slv8_sr = slv8_sr << 1;
    always @(posedge sclk8) if (!cs8) cap8 = {cap8[6:0], mosi8};

    // Frame/gap monitor on the default instance, plus MOSI legality tracking.
    logic mon_clr = 1'b0;
    int   frames = 0, dones = 0, min_gap = 1000, high_run = 0, viol = 0;
    logic cs_q = 1'b1, sclk_q = 1'b0, mosi_q = 1'b0;
    always @(negedge clk) begin
        if (mon_clr) begin
            frames = 0; dones = 0; min_gap = 1000; high_run = 0;
        end else begin
            if (done) dones++;
            if (cs_q && !cs) begin
                frames++;
                if (frames > 1 && high_run < min_gap) min_gap = high_run;
            end
            if (cs) high_run++; else high_run = 0;
        end
        if (cs && mosi) viol++;
        if (!cs && !cs_q && mosi !== mosi_q && !(sclk_q && !sclk)) viol++;
        cs_q = cs; sclk_q = sclk; mosi_q = mosi;
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_mon();
        mon_clr = 1'b1;
        tick();
        mon_clr = 1'b0;
    endtask

    int cyc, r1, r2;
    logic prev;

    initial begin
        // Reset values
        repeat (3) tick();
        check("rst_cs", 32'(cs), 1);
        check("rst_sclk", 32'(sclk), 0);
        check("rst_mosi", 32'(mosi), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_rx", rx, 0);
        rst_n = 1'b1;
        repeat (2) tick();

        // Basic frame with loopback slave
        tx = 32'hA5C3_0F01; start = 1'b1;
        tick();
        start = 1'b0; cyc = 1;
        check("launch_cs", 32'(cs), 0);
        check("launch_busy", 32'(busy), 1);
        check("launch_mosi_msb", 32'(mosi), 1);
        check("launch_sclk", 32'(sclk), 0);
        while (!done && cyc < 400) begin tick(); cyc++; end
        check("done_cycle", 32'(cyc), 261);
        check("rx_word", rx, 32'h1234_5678);
        check("mosi_stream", cap, 32'hA5C3_0F01);
        check("done_cs_high", 32'(cs), 1);
        tick(); cyc++;
        check("done_one_cycle", 32'(done), 0);
        while (busy && cyc < 400) begin tick(); cyc++; end
        check("busy_fall_cycle", 32'(cyc), 265);

        // start_i held high: back-to-back frames
        clear_mon();
        start = 1'b1; cyc = 0;
        while (frames < 3 && cyc < 1000) begin tick(); cyc++; end
        start = 1'b0;
        while (busy && cyc < 2000) begin tick(); cyc++; end
        check("held_frames", 32'(frames), 3);
        check("held_min_gap", 32'(min_gap), 5);
        check("held_dones", 32'(dones), 3);

        // Interrupt-driven frames; extra irqs collapse into one pending event
        clear_mon();
        auto_en = 1'b1;
        irq = 1'b1; tick(); irq = 1'b0;
        repeat (50) tick();
        check("irq_launch_busy", 32'(busy), 1);
        for (int i = 0; i < 3; i++) begin
            irq = 1'b1; tick(); irq = 1'b0;
            repeat (20) tick();
        end
        repeat (700) tick();
        check("irq_frames", 32'(frames), 2);
        check("irq_dones", 32'(dones), 2);
        check("irq_idle", 32'(busy), 0);
        auto_en = 1'b0;

        // irq with auto_en low is dropped, not deferred
        clear_mon();
        irq = 1'b1; tick(); irq = 1'b0;
        repeat (10) tick();
        auto_en = 1'b1;
        repeat (300) tick();
        check("noauto_frames", 32'(frames), 0);
        check("noauto_busy", 32'(busy), 0);
        auto_en = 1'b0;

        // Reset mid-frame
        clear_mon();
        tx = 32'hFFFF_FFFF; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (99) tick();
        rst_n = 1'b0;
        tick();
        check("abort_cs", 32'(cs), 1);
        check("abort_sclk", 32'(sclk), 0);
        check("abort_mosi", 32'(mosi), 0);
        check("abort_busy", 32'(busy), 0);
        check("abort_rx", rx, 0);
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (300) tick();
        check("abort_no_done", 32'(dones), 0);
        check("abort_rx_held", rx, 0);

        // 8-bit, CLK_DIV=2 instance
        tx8 = 8'hC3; start8 = 1'b1;
        tick();
        start8 = 1'b0; cyc = 1; r1 = 0; r2 = 0; prev = sclk8;
        while (!done8 && cyc < 100) begin
            tick(); cyc++;
            if (sclk8 && !prev) begin
                if (r1 == 0) r1 = cyc;
                else if (r2 == 0) r2 = cyc;
            end
            prev = sclk8;
        end
        check("d8_done_cycle", 32'(cyc), 37);
        check("d8_first_rise", 32'(r1), 5);
        check("d8_sclk_period", 32'(r2 - r1), 4);
        check("d8_rx", 32'(rx8), 32'h5A);
        check("d8_mosi_stream", 32'(cap8), 32'hC3);

        check("mosi_legal", 32'(viol), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
